// File: rtl/segway_pkg.sv
// Shared types and constants for the segway digital core.
package segway_pkg;

    // Rider/steering qualifier states; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        STEER = 2'b10
    } steer_state_t;

    // Default weight thresholds (raw A2D counts, left + right summed).
    localparam logic [11:0] DEF_MIN_RIDER_WT = 12'h200;
    localparam logic [11:0] DEF_WT_HYST      = 12'h040;

    // Steady-stance timer widths: short for simulation, ~1.34 s at 50 MHz in hardware.
    localparam int TMR_W_SIM = 15;
    localparam int TMR_W_HW  = 26;

endpackage

// File: rtl/steer_tmr.sv
// Saturating steady-stance timer: counts every clock, cleared on demand,
// sticks at all-ones so a long stance can never wrap back to "not full".
module steer_tmr #(
    parameter int W = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic full
);

    logic [W-1:0] cnt;

    assign full = &cnt;

    // Count up until full; clear has priority over saturation.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!full) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/rider_steer_en.sv
// Rider-presence and steering-enable qualifier. Captures load-cell readings,
// decides whether a rider is mounted and standing level, and enables steering
// once the stance has been steady for a full timer period.
module rider_steer_en
    import segway_pkg::*;
#(
    parameter logic        fast_sim     = 1'b0,
    parameter logic [11:0] MIN_RIDER_WT = DEF_MIN_RIDER_WT,
    parameter logic [11:0] WT_HYST      = DEF_WT_HYST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic        ld_vld,
    output logic        en_steer,
    output logic        rider_off
);

    localparam int          TMR_W   = fast_sim ? TMR_W_SIM : TMR_W_HW;
    localparam logic [12:0] ON_WT   = {1'b0, MIN_RIDER_WT};
    localparam logic [12:0] LOST_WT = {1'b0, MIN_RIDER_WT - WT_HYST};

    logic [11:0]  lft_r, rght_r;
    logic [12:0]  sum;
    logic [11:0]  diff;
    logic         sum_gt_min, sum_lt_min;
    logic         diff_gt_1_4, diff_gt_15_16;
    logic         clr_tmr, tmr_full;
    steer_state_t state, nxt_state;

    // Hold the most recent valid load-cell pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_r  <= '0;
            rght_r <= '0;
        end else if (ld_vld) begin
            lft_r  <= lft_ld;
            rght_r <= rght_ld;
        end
    end

    // Total weight and left/right imbalance of the captured readings.
    always_comb begin
        sum  = {1'b0, lft_r} + {1'b0, rght_r};
        diff = (lft_r >= rght_r) ? (lft_r - rght_r) : (rght_r - lft_r);
    end

    // Between LOST_WT and ON_WT neither flag is set, giving the weight hysteresis.
    assign sum_gt_min    = sum > ON_WT;
    assign sum_lt_min    = sum < LOST_WT;
    // Tight imbalance limit while waiting, loose limit once steering.
    assign diff_gt_1_4   = {1'b0, diff} > (sum >> 2);
    assign diff_gt_15_16 = {1'b0, diff} > (sum - (sum >> 4));

    steer_tmr #(.W(TMR_W)) u_tmr (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_tmr),
        .full (tmr_full)
    );

    // Next-state logic; weight loss outranks imbalance in every state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        nxt_state = state;
        clr_tmr   = 1'b0;
        case (state)
            IDLE: begin
                if (sum_gt_min) begin
                    nxt_state = WAIT;
                    clr_tmr   = 1'b1;
                end
            end
            WAIT: begin
                if (sum_lt_min) begin
                    nxt_state = IDLE;
                end else if (diff_gt_1_4) begin
                    clr_tmr   = 1'b1;
                end else if (tmr_full) begin
                    nxt_state = STEER;
                end
            end
            STEER: begin
                if (sum_lt_min) begin
                    nxt_state = IDLE;
                end else if (diff_gt_15_16) begin
                    nxt_state = WAIT;
                    clr_tmr   = 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // State and Moore outputs register together so outputs track the state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            en_steer  <= 1'b0;
            rider_off <= 1'b1;
        end else begin
            state     <= nxt_state;
            en_steer  <= (nxt_state == STEER);
            rider_off <= (nxt_state == IDLE);
        end
    end

endmodule

// File: tb/tb_rider_steer_en.sv
// Self-checking bench for rider_steer_en (fast_sim=1): directed scenarios
// plus randomized loads compared against a behavioural rider model.
module tb_rider_steer_en;

    localparam int TMR_MAX = (1 << 15) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        ld_vld;
    logic        en_steer;
    logic        rider_off;

    int n_vec = 0;
    int n_err = 0;

    rider_steer_en #(.fast_sim(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .ld_vld    (ld_vld),
        .en_steer  (en_steer),
        .rider_off (rider_off)
    );

    always #5 clk = ~clk;

    // Behavioural rider model: mode 0 = nobody on, 1 = mounted and settling,
    // 2 = steering. steady counts cycles since the stance was last disturbed.
    int m_lft, m_rght, m_mode, m_steady;

    always @(posedge clk or posedge rst) begin : model
        int total, imbal, mode_n, steady_n;
        bit heavy, light;
        if (rst) begin
            m_lft    <= 0;
            m_rght   <= 0;
            m_mode   <= 0;
            m_steady <= 0;
        end else begin
            total    = m_lft + m_rght;
            imbal    = (m_lft > m_rght) ? m_lft - m_rght : m_rght - m_lft;
            heavy    = total > 'h200;
            light    = total < 'h1C0;
            mode_n   = m_mode;
            steady_n = (m_steady < TMR_MAX) ? m_steady + 1 : m_steady;
            if (m_mode == 0) begin
                if (heavy) begin
                    mode_n   = 1;
                    steady_n = 0;
                end
            end else if (light) begin
                mode_n = 0;
            end else if (m_mode == 1) begin
                if (4 * imbal > total) steady_n = 0;
                else if (m_steady == TMR_MAX) mode_n = 2;
            end else if (imbal > total - total / 16) begin
                mode_n   = 1;
                steady_n = 0;
            end
            m_mode   <= mode_n;
            m_steady <= steady_n;
            if (ld_vld) begin
                m_lft  <= int'(lft_ld);
                m_rght <= int'(rght_ld);
            end
        end
    end

    // Present one load pair for a single cycle; returns on the following negedge.
    task automatic drive(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
        ld_vld  = 1'b1;
        @(negedge clk);
        ld_vld  = 1'b0;
    endtask

    task automatic test_reset();
        int bad = 0;
        #8;
        n_vec++;
        if (en_steer !== 1'b0 || rider_off !== 1'b1) begin
            $display("FAIL reset_values: en_steer=%b rider_off=%b, want 0/1", en_steer, rider_off);
            n_err++;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (i % 10 == 0) drive(12'h000, 12'h000);
            else @(negedge clk);
            if (en_steer !== 1'b0 || rider_off !== 1'b1) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            $display("FAIL idle_empty: %0d bad cycles, want 0", bad);
            n_err++;
        end
    endtask

    task automatic test_reset_mid_wait();
        int bad = 0;
        drive(12'h180, 12'h180);
        repeat (16383) @(negedge clk);
        n_vec++;
        if (en_steer !== 1'b0 || rider_off !== 1'b0) begin
            $display("FAIL mid_wait: en_steer=%b rider_off=%b, want 0/0", en_steer, rider_off);
            n_err++;
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (en_steer !== 1'b0 || rider_off !== 1'b1) begin
            $display("FAIL async_reset: en_steer=%b rider_off=%b, want 0/1", en_steer, rider_off);
            n_err++;
        end
        @(negedge clk);
        rst = 1'b0;
        // Captured loads are cleared, so no rider is seen even though the inputs still hold weight.
        repeat (20) begin
            @(negedge clk);
            if (rider_off !== 1'b1 || en_steer !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            $display("FAIL post_reset_idle: %0d bad cycles, want 0", bad);
            n_err++;
        end
    endtask

    task automatic test_wait_to_steer();
        int k = 1;
        int bad = 0;
        drive(12'h180, 12'h180);
        n_vec++;
        if (rider_off !== 1'b1) begin
            $display("FAIL capture_latency: rider_off=%b at N+1, want 1", rider_off);
            n_err++;
        end
        while (k < 40000 && en_steer !== 1'b1) begin
            @(negedge clk);
            k++;
            if (rider_off !== 1'b0) bad++;
        end
        n_vec++;
        if (k != 32770) begin
            $display("FAIL steer_delay: en_steer rose %0d cycles after ld_vld, want 32770", k);
            n_err++;
        end
        n_vec++;
        if (bad != 0) begin
            $display("FAIL rider_on_in_wait: %0d cycles with rider_off high, want 0", bad);
            n_err++;
        end
    endtask

    task automatic test_steer_imbalance();
        drive(12'h300, 12'h100);
        repeat (20) @(negedge clk);
        n_vec++;
        if (en_steer !== 1'b1 || rider_off !== 1'b0) begin
            $display("FAIL steer_hold_diff: en_steer=%b rider_off=%b, want 1/0", en_steer, rider_off);
            n_err++;
        end
        drive(12'h300, 12'h010);
        n_vec++;
        if (en_steer !== 1'b1) begin
            $display("FAIL steer_diff_n1: en_steer=%b, want 1", en_steer);
            n_err++;
        end
        @(negedge clk);
        n_vec++;
        if (en_steer !== 1'b0 || rider_off !== 1'b0) begin
            $display("FAIL steer_to_wait: en_steer=%b rider_off=%b, want 0/0", en_steer, rider_off);
            n_err++;
        end
    endtask

    task automatic test_wait_imbalance();
        int k = 1;
        drive(12'h180, 12'h180);
        repeat (1999) @(negedge clk);
        drive(12'h300, 12'h050);
        repeat (9) @(negedge clk);
        n_vec++;
        if (en_steer !== 1'b0 || rider_off !== 1'b0) begin
            $display("FAIL wait_tilted: en_steer=%b rider_off=%b, want 0/0", en_steer, rider_off);
            n_err++;
        end
        drive(12'h180, 12'h180);
        while (k < 40000 && en_steer !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k != 32769) begin
            $display("FAIL tmr_restart: en_steer rose %0d cycles after rebalance, want 32769", k);
            n_err++;
        end
    endtask

    task automatic test_hysteresis();
        drive(12'h0F0, 12'h0F0);
        repeat (20) @(negedge clk);
        n_vec++;
        if (en_steer !== 1'b1) begin
            $display("FAIL steer_band_hold: en_steer=%b, want 1", en_steer);
            n_err++;
        end
        drive(12'h0D8, 12'h0D8);
        n_vec++;
        if (rider_off !== 1'b0 || en_steer !== 1'b1) begin
            $display("FAIL lost_n1: rider_off=%b en_steer=%b, want 0/1", rider_off, en_steer);
            n_err++;
        end
        @(negedge clk);
        n_vec++;
        if (rider_off !== 1'b1 || en_steer !== 1'b0) begin
            $display("FAIL lost_n2: rider_off=%b en_steer=%b, want 1/0", rider_off, en_steer);
            n_err++;
        end
        drive(12'h0F8, 12'h0F8);
        repeat (20) @(negedge clk);
        n_vec++;
        if (rider_off !== 1'b1) begin
            $display("FAIL idle_band_hold: rider_off=%b, want 1", rider_off);
            n_err++;
        end
        drive(12'h100, 12'h100);
        repeat (5) @(negedge clk);
        n_vec++;
        if (rider_off !== 1'b1) begin
            $display("FAIL sum_eq_min: rider_off=%b, want 1", rider_off);
            n_err++;
        end
        drive(12'h101, 12'h100);
        @(negedge clk);
        n_vec++;
        if (rider_off !== 1'b0 || en_steer !== 1'b0) begin
            $display("FAIL sum_above_min: rider_off=%b en_steer=%b, want 0/0", rider_off, en_steer);
            n_err++;
        end
        drive(12'h1C0, 12'h000);
        repeat (5) @(negedge clk);
        n_vec++;
        if (rider_off !== 1'b0) begin
            $display("FAIL sum_eq_lost: rider_off=%b, want 0", rider_off);
            n_err++;
        end
        drive(12'h1BF, 12'h000);
        @(negedge clk);
        n_vec++;
        if (rider_off !== 1'b1 || en_steer !== 1'b0) begin
            $display("FAIL weight_priority: rider_off=%b en_steer=%b, want 1/0", rider_off, en_steer);
            n_err++;
        end
    endtask

    task automatic test_random();
        int sums[6] = '{'h1BF, 'h1C0, 'h1E0, 'h200, 'h201, 'h300};
        int s, l;
        for (int i = 0; i < 4000; i++) begin
            n_vec++;
            if (en_steer !== (m_mode == 2) || rider_off !== (m_mode == 0)) begin
                $display("FAIL random_%0d: en_steer=%b rider_off=%b, model mode %0d",
                         i, en_steer, rider_off, m_mode);
                n_err++;
            end
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0: begin
                        lft_ld  = 12'($urandom_range(0, 4095));
                        rght_ld = 12'($urandom_range(0, 4095));
                    end
                    1: begin
                        s = sums[$urandom_range(0, 5)];
                        l = s / 2 + int'($urandom_range(0, 64)) - 32;
                        lft_ld  = 12'(l);
                        rght_ld = 12'(s - l);
                    end
                    default: begin
                        s = sums[$urandom_range(0, 5)];
                        l = int'($urandom_range(0, 32'(s)));
                        lft_ld  = 12'(l);
                        rght_ld = 12'(s - l);
                    end
                endcase
                ld_vld = 1'b1;
            end else begin
                ld_vld = 1'b0;
            end
            @(negedge clk);
        end
        ld_vld = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        lft_ld  = '0;
        rght_ld = '0;
        ld_vld  = 1'b0;
        test_reset();
        test_reset_mid_wait();
        test_wait_to_steer();
        test_steer_imbalance();
        test_wait_imbalance();
        test_hysteresis();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
